bank_writer: RTL and testbench
==============================

Name: bank_writer

Overview:
- Write-side router for the POY-bank line buffer: accepts rows of BUFW words on a valid/ready stream and steers each row into one bank, filling banks round-robin.
- Tracks per-bank full status and presents the oldest full bank as a 2-bit bank index. That index drives the existing read-side bank select mux.
- The consumer releases a bank when finished, and the released bank becomes writable again.

Parameters:
- DW, 1, bits per word.
- POY, 3, number of banks (2..4; the bank index is fixed at 2 bits).
- BUFW, 32, words per row.
- DEPTH, 4, rows per bank.
- AW, $clog2(DEPTH), row address width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear, same effect as rst (frame restart).
- idata  in  [DW-1:0] x BUFW (unpacked)  input row.
- ivalid  in  1  row valid.
- iready  out  1  row accepted when ivalid && iready.
- wen  out  POY  one-hot bank write strobe (registered).
- waddr  out  AW  row address within bank (registered).
- wdata  out  [DW-1:0] x BUFW  row data to all banks (registered).
- bank_full  out  POY  bank i holds DEPTH valid rows.
- rd_bank  out  2  oldest full bank, feeds the read mux bank select.
- rd_valid  out  1  bank_full[rd_bank].
- rd_release  in  1  one-cycle pulse: consumer finished with rd_bank.

Behaviour:
- Reset/clear, next edge:
  - wen=0, waddr=0, wdata=0, bank_full=0, rd_bank=0, rd_valid=0.
  - wr_bank=0, wr_row=0, state=FILL.
- clear overrides all same-cycle events, including accept and release.
- FSM, 2 states:
  - FILL: iready=1.
  - STALL: iready=0, entered when bank_full[wr_bank] is set.
  - iready is combinational from the state only, never from ivalid.
- Accept (FILL && ivalid), next cycle:
  - wen[wr_bank]=1, waddr=wr_row, wdata=idata. Write latency is exactly 1 cycle.
  - wen is all-zero on cycles with no accept.
- Row counter:
  - On accept with wr_row<DEPTH-1: wr_row++.
  - On accept with wr_row==DEPTH-1:
    - wr_row<=0.
    - bank_full[wr_bank]<=1, visible the cycle after the last row's wen.
    - wr_bank<=(wr_bank==POY-1)?0:wr_bank+1.
    - If the new wr_bank is already full, go to STALL; otherwise stay in FILL.
- STALL -> FILL: the cycle after bank_full[wr_bank] clears. Back-to-back accept is allowed on that cycle.
- Release (rd_release && rd_valid):
  - Clears bank_full[rd_bank].
  - rd_bank advances with the same wrap rule as wr_bank.
  - rd_release while !rd_valid is ignored; no state changes.
- Simultaneous fill-complete on bank A and release on bank B: both take effect in the same cycle. A==B is impossible, since a full bank is never written.
- Order guarantee: rd_bank always equals the oldest filled bank. Banks are released strictly in fill order.
- All POY banks full: iready=0 until a release.
- ivalid held high while iready=0: no write, and the row is held by the producer.

Decomposition:
- Shared package line_buf_pkg:
  - BANK_W=2 constant.
  - typedef of the bank index.
  - State enum {FILL, STALL}.
  - Function next_bank(idx, POY) implementing the wrap increment, used by both pointers.
- No sub-module. A single flat module (~150 lines) is the natural size.

Test Plan (POY=3, DEPTH=4, BUFW=4, DW=8):
1. Reset, then 4 rows 0x10..0x13 with ivalid steady:
   - wen=3'b001 on the 4 cycles after each accept, waddr 0..3.
   - bank_full=3'b001 the cycle after the last wen.
   - rd_bank=0, rd_valid=1.
2. 12 rows streamed with no release:
   - banks fill 0, 1, 2 and bank_full=3'b111.
   - iready=0 from the cycle after the 12th accept.
   - 13th row held with no wen.
3. From scenario 2, pulse rd_release:
   - bank_full=3'b110, rd_bank=1.
   - iready=1 one cycle later.
   - 13th row written wen=3'b001, waddr=0.
4. rd_release on the same cycle as the final row accept into bank 1 (bank 0 full):
   - bank 0 cleared, bank 1 set.
   - rd_bank=1, rd_valid=1.
5. rd_release pulsed with bank_full=0 → no change: rd_bank=0, rd_valid=0.
6. clear asserted mid-bank (wr_row=2) together with ivalid:
   - no wen next cycle.
   - all outputs return to reset values.
   - the next accept writes bank 0, row 0.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared types for the POY-bank line buffer: bank index, writer FSM states
// and the round-robin bank pointer increment.
package line_buf_pkg;

  localparam int BANK_W = 2;

  typedef logic [BANK_W-1:0] bank_idx_t;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } wr_state_t;

  // Wraps to bank 0 after the last populated bank.
  function automatic bank_idx_t next_bank(input bank_idx_t idx, input int unsigned poy);
    return (idx == bank_idx_t'(poy - 1)) ? '0 : bank_idx_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/bank_writer.sv
// Write-side router for the POY-bank line buffer: steers accepted rows into
// banks round-robin and presents the oldest full bank to the read side.
module bank_writer
  import line_buf_pkg::*;
#(
  parameter int DW    = 1,
  parameter int POY   = 3,
  parameter int BUFW  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [DW-1:0] idata [BUFW],
  input  logic          ivalid,
  output logic          iready,
  output logic [POY-1:0] wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata [BUFW],
  output logic [POY-1:0] bank_full,
  output logic [1:0]    rd_bank,
  output logic          rd_valid,
  input  logic          rd_release,
  output logic          o_dbg_state
);

  // Row stream: a row transfers on a cycle where ivalid && iready; iready
  // depends only on the FSM state, and the producer holds the row while low.

  wr_state_t       r_state;
  wr_state_t       w_next_state;
  bank_idx_t       r_wr_bank;
  bank_idx_t       r_rd_bank;
  logic [AW-1:0]   r_wr_row;
  logic [POY-1:0]  r_bank_full;
  logic [POY-1:0]  r_wen;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata [BUFW];

  logic            w_accept;
  logic            w_release;
  logic            w_last_row;
  bank_idx_t       w_new_wr_bank;
  logic [POY-1:0]  w_set;
  logic [POY-1:0]  w_clr;
  logic [POY-1:0]  w_full_after;
  logic [POY-1:0]  w_wen_nxt;

  always_comb begin
    w_accept      = (r_state == FILL) && ivalid;
    w_release     = rd_release && r_bank_full[r_rd_bank];
    w_last_row    = (r_wr_row == AW'(DEPTH - 1));
    w_new_wr_bank = next_bank(r_wr_bank, POY);
    // A bank becomes full once its last row has actually been written.
    w_set         = (r_waddr == AW'(DEPTH - 1)) ? r_wen : '0;
    w_clr         = '0;
    if (w_release) w_clr[r_rd_bank] = 1'b1;
    w_full_after  = (r_bank_full | w_set) & ~w_clr;
    w_wen_nxt     = '0;
    if (w_accept) w_wen_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= FILL;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL:    if (w_accept && w_last_row && w_full_after[w_new_wr_bank]) w_next_state = STALL;
      STALL:   if (!r_bank_full[r_wr_bank]) w_next_state = FILL;
      default: w_next_state = FILL;
    endcase
  end

  always_comb begin
    iready      = (r_state == FILL);
    o_dbg_state = logic'(r_state);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_bank   <= '0;
      r_rd_bank   <= '0;
      r_wr_row    <= '0;
      r_bank_full <= '0;
      r_wen       <= '0;
      r_waddr     <= '0;
      for (int i = 0; i < BUFW; i++) r_wdata[i] <= '0;
    end else begin
      r_wen       <= w_wen_nxt;
      r_bank_full <= (r_bank_full & ~w_clr) | w_set;
      if (w_release) r_rd_bank <= next_bank(r_rd_bank, POY);
      if (w_accept) begin
        r_waddr <= r_wr_row;
        r_wdata <= idata;
        if (w_last_row) begin
          r_wr_row  <= '0;
          r_wr_bank <= w_new_wr_bank;
        end else begin
          r_wr_row  <= r_wr_row + 1'b1;
        end
      end
    end
  end

  assign wen       = r_wen;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign bank_full = r_bank_full;
  assign rd_bank   = r_rd_bank;
  assign rd_valid  = r_bank_full[r_rd_bank];

endmodule

// File: tb/tb_bank_writer.sv
// Directed bench for bank_writer with a queue-based reference model of bank
// filling, release order and producer stalls.
module tb_bank_writer;

  localparam int DW    = 8;
  localparam int POY   = 3;
  localparam int BUFW  = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic ivalid = 1'b0;
  logic rd_release = 1'b0;
  logic iready, rd_valid, dbg_state;
  logic [DW-1:0]  idata [BUFW];
  logic [DW-1:0]  wdata [BUFW];
  logic [POY-1:0] wen, bank_full;
  logic [AW-1:0]  waddr;
  logic [1:0]     rd_bank;

  always #5 clk = ~clk;

  bank_writer #(.DW(DW), .POY(POY), .BUFW(BUFW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .idata(idata), .ivalid(ivalid),
    .iready(iready), .wen(wen), .waddr(waddr), .wdata(wdata),
    .bank_full(bank_full), .rd_bank(rd_bank), .rd_valid(rd_valid),
    .rd_release(rd_release), .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_w();
    return {wdata[3], wdata[2], wdata[1], wdata[0]};
  endfunction

  function automatic logic [31:0] pack_i();
    return {idata[3], idata[2], idata[1], idata[0]};
  endfunction

  // ---------------- reference model ----------------
  // exp_q holds banks whose filling is complete and not yet released, oldest first.
  logic [1:0]     exp_q[$];
  bit             m_started = 0;
  bit             m_full [POY];
  int             m_pend;
  int             m_wr_bank, m_wr_row, m_rel_cnt;
  bit             m_ready;
  logic [POY-1:0] m_exp_wen;
  logic [AW-1:0]  m_exp_waddr;
  logic [31:0]    m_exp_wdata;

  task automatic model_step();
    bit acc, rel, wr_full_before;
    int rd;
    if (rst || clear) begin
      m_started = 1;
      for (int k = 0; k < POY; k++) m_full[k] = 0;
      m_pend = -1;
      exp_q.delete();
      m_wr_bank = 0; m_wr_row = 0; m_rel_cnt = 0;
      m_ready = 1; m_exp_wen = '0;
    end else begin
      rd = m_rel_cnt % POY;
      acc = m_ready && ivalid;
      rel = rd_release && m_full[rd];
      wr_full_before = m_full[m_wr_bank];
      if (m_pend >= 0) m_full[m_pend] = 1;
      m_pend = -1;
      if (rel) begin
        m_full[rd] = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_rel_cnt++;
      end
      m_exp_wen = '0;
      if (acc) begin
        m_exp_wen   = POY'(1 << m_wr_bank);
        m_exp_waddr = AW'(m_wr_row);
        m_exp_wdata = pack_i();
        if (m_wr_row == DEPTH - 1) begin
          m_pend = m_wr_bank;
          exp_q.push_back(2'(m_wr_bank));
          m_wr_bank = (m_wr_bank + 1) % POY;
          m_wr_row = 0;
          m_ready = 1;
          foreach (exp_q[k]) if (exp_q[k] == 2'(m_wr_bank)) m_ready = 0;
        end else begin
          m_wr_row++;
        end
      end else if (!m_ready) begin
        m_ready = !wr_full_before;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      logic [POY-1:0] f;
      int rd;
      rd = m_rel_cnt % POY;
      for (int k = 0; k < POY; k++) f[k] = m_full[k];
      chk("iready", 32'(iready), 32'(m_ready));
      chk("dbg_state", 32'(dbg_state), 32'(!m_ready));
      chk("wen", 32'(wen), 32'(m_exp_wen));
      if (m_exp_wen != '0) begin
        chk("waddr", 32'(waddr), 32'(m_exp_waddr));
        chk("wdata", pack_w(), m_exp_wdata);
      end
      chk("bank_full", 32'(bank_full), 32'(f));
      chk("rd_bank", 32'(rd_bank), 32'(rd));
      chk("rd_valid", 32'(rd_valid), 32'(m_full[rd]));
      if (m_full[rd] && exp_q.size() > 0) chk("rd_order", 32'(rd_bank), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_row(input logic [7:0] base);
    for (int j = 0; j < BUFW; j++) idata[j] = base ^ 8'(j << 6);
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; ivalid = 1'b0; rd_release = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    set_row(8'h00);
    cyc();
    do_reset();

    // reset state
    chk("rst_wen", 32'(wen), 32'h0);
    chk("rst_waddr", 32'(waddr), 32'h0);
    chk("rst_wdata", pack_w(), 32'h0);
    chk("rst_bank_full", 32'(bank_full), 32'h0);
    chk("rst_rd_bank", 32'(rd_bank), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_iready", 32'(iready), 32'h1);

    // 1: four rows into bank 0
    ivalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_row(8'(8'h10 + i));
      cyc();
      chk("s1_wen", 32'(wen), 32'h1);
      chk("s1_waddr", 32'(waddr), 32'(i));
    end
    chk("s1_full_lag", 32'(bank_full), 32'h0);
    ivalid = 1'b0;
    cyc();
    chk("s1_bank_full", 32'(bank_full), 32'h1);
    chk("s1_rd_bank", 32'(rd_bank), 32'h0);
    chk("s1_rd_valid", 32'(rd_valid), 32'h1);

    // 2: twelve rows fill all banks
    do_reset();
    ivalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_row(8'(8'h20 + i));
      cyc();
    end
    chk("s2_iready", 32'(iready), 32'h0);
    chk("s2_last_wen", 32'(wen), 32'h4);
    set_row(8'h5c);
    cyc();
    chk("s2_bank_full", 32'(bank_full), 32'h7);
    chk("s2_hold_wen", 32'(wen), 32'h0);
    cyc();
    chk("s2_hold_wen2", 32'(wen), 32'h0);

    // 3: release bank 0, the held row goes in
    rd_release = 1'b1;
    cyc();
    rd_release = 1'b0;
    chk("s3_bank_full", 32'(bank_full), 32'h6);
    chk("s3_rd_bank", 32'(rd_bank), 32'h1);
    chk("s3_iready_lo", 32'(iready), 32'h0);
    cyc();
    chk("s3_iready", 32'(iready), 32'h1);
    cyc();
    chk("s3_wen", 32'(wen), 32'h1);
    chk("s3_waddr", 32'(waddr), 32'h0);
    chk("s3_wdata", pack_w(), 32'h9c_dc_1c_5c);
    ivalid = 1'b0;
    cyc();

    // 4: release bank 0 while finishing bank 1
    do_reset();
    ivalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_row(8'(8'h30 + i));
      if (i == 7) rd_release = 1'b1;
      cyc();
    end
    ivalid = 1'b0; rd_release = 1'b0;
    chk("s4_bank_full_mid", 32'(bank_full), 32'h0);
    chk("s4_rd_bank", 32'(rd_bank), 32'h1);
    cyc();
    chk("s4_bank_full", 32'(bank_full), 32'h2);
    chk("s4_rd_valid", 32'(rd_valid), 32'h1);

    // 5: release with nothing full is ignored
    do_reset();
    rd_release = 1'b1;
    cyc();
    rd_release = 1'b0;
    chk("s5_rd_bank", 32'(rd_bank), 32'h0);
    chk("s5_rd_valid", 32'(rd_valid), 32'h0);
    chk("s5_bank_full", 32'(bank_full), 32'h0);

    // 6: clear mid-bank with ivalid high
    ivalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_row(8'(8'h40 + i));
      cyc();
    end
    clear = 1'b1;
    set_row(8'h4f);
    cyc();
    clear = 1'b0;
    chk("s6_wen", 32'(wen), 32'h0);
    chk("s6_waddr", 32'(waddr), 32'h0);
    chk("s6_wdata", pack_w(), 32'h0);
    chk("s6_iready", 32'(iready), 32'h1);
    set_row(8'h77);
    cyc();
    chk("s6_next_wen", 32'(wen), 32'h1);
    chk("s6_next_waddr", 32'(waddr), 32'h0);
    ivalid = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
